// File: rtl/alu_pkg.sv
// Shared constants, opcode encodings and instruction field layout for the 8-bit ALU
// issue stage.
package alu_pkg;

  localparam int ALU_DW   = 8;
  localparam int ALU_RAW  = 2;
  localparam int ALU_CNTW = 16;
  localparam int ALU_IW   = 16;

  localparam int OP_LSB = 12;
  localparam int RD_LSB = 10;
  localparam int RS_LSB = 8;
  localparam int RT_LSB = 6;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_SUBI = 4'b0010;
  localparam logic [3:0] OP_ANDI = 4'b0011;
  localparam logic [3:0] OP_ORI  = 4'b0100;
  localparam logic [3:0] OP_XORI = 4'b0101;
  localparam logic [3:0] OP_LLSI = 4'b0110;
  localparam logic [3:0] OP_LRSI = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b1010;
  localparam logic [3:0] OP_OR   = 4'b1011;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_LLS  = 4'b1101;
  localparam logic [3:0] OP_ILL  = 4'b1110;
  localparam logic [3:0] OP_LRS  = 4'b1111;

  typedef enum logic [1:0] {
    CLS_NOP,
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify_op(input logic [3:0] op);
    if (op == OP_NOP) return CLS_NOP;
    if (op == OP_ILL) return CLS_ILLEGAL;
    if (op[3]) return CLS_RTYPE;
    return CLS_ITYPE;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction decode: splits fields and classifies the opcode.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [ALU_IW-1:0]  instr,
  output logic [3:0]         op,
  output logic [ALU_RAW-1:0] rd,
  output logic [ALU_RAW-1:0] rs,
  output logic [ALU_RAW-1:0] rt,
  output logic [7:0]         imm8,
  output logic               is_imm,
  output logic               is_nop,
  output logic               is_illegal
);

  op_class_e op_class;

  always_comb begin
    op         = instr[OP_LSB +: 4];
    rd         = instr[RD_LSB +: ALU_RAW];
    rs         = instr[RS_LSB +: ALU_RAW];
    rt         = instr[RT_LSB +: ALU_RAW];
    imm8       = instr[7:0];
    op_class   = classify_op(op);
    is_imm     = (op_class == CLS_ITYPE);
    is_nop     = (op_class == CLS_NOP);
    is_illegal = (op_class == CLS_ILLEGAL);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue stage in front of the ALU: skid-buffered input, regfile read with
// writeback forwarding, registered operand output with stall-time writeback snooping.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DW   = ALU_DW,
  parameter int RAW  = ALU_RAW,
  parameter int CNTW = ALU_CNTW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_instr,
  output logic [RAW-1:0]  rf_raddr0,
  output logic [RAW-1:0]  rf_raddr1,
  input  logic [DW-1:0]   rf_rdata0,
  input  logic [DW-1:0]   rf_rdata1,
  input  logic            wb_we,
  input  logic [RAW-1:0]  wb_addr,
  input  logic [DW-1:0]   wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [3:0]      ex_op,
  output logic [DW-1:0]   ex_a,
  output logic [DW-1:0]   ex_b,
  output logic [RAW-1:0]  ex_rd,
  output logic            err_illegal,
  output logic [CNTW-1:0] issue_cnt
);

  logic            skid_valid_q, skid_valid_d;
  logic [15:0]     skid_instr_q, skid_instr_d;
  logic            in_ready_q, in_ready_d;
  logic            ex_valid_q, ex_valid_d;
  logic [3:0]      ex_op_q, ex_op_d;
  logic [DW-1:0]   ex_a_q, ex_a_d;
  logic [DW-1:0]   ex_b_q, ex_b_d;
  logic [RAW-1:0]  ex_rd_q, ex_rd_d;
  logic [RAW-1:0]  ex_rs_q, ex_rs_d;
  logic [RAW-1:0]  ex_rt_q, ex_rt_d;
  logic            ex_snoop_b_q, ex_snoop_b_d;
  logic            err_q, err_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            accept;
  logic            src_valid;
  logic [15:0]     src_instr;
  logic            can_load;
  logic            consume;
  logic            stall;
  logic [3:0]      dec_op;
  logic [RAW-1:0]  dec_rd, dec_rs, dec_rt;
  logic [7:0]      dec_imm8;
  logic            dec_is_imm, dec_is_nop, dec_is_illegal;
  logic [DW-1:0]   fwd_a, fwd_b;

  // The skid entry is always older than anything on the input, so it decodes first.
  assign accept    = in_valid && in_ready_q;
  assign src_valid = skid_valid_q || accept;
  assign src_instr = skid_valid_q ? skid_instr_q : in_instr;
  assign can_load  = !ex_valid_q || ex_ready;
  assign consume   = src_valid && can_load;
  assign stall     = ex_valid_q && !ex_ready;

  alu_issue_decode u_decode (
    .instr      (src_instr),
    .op         (dec_op),
    .rd         (dec_rd),
    .rs         (dec_rs),
    .rt         (dec_rt),
    .imm8       (dec_imm8),
    .is_imm     (dec_is_imm),
    .is_nop     (dec_is_nop),
    .is_illegal (dec_is_illegal)
  );

  assign rf_raddr0 = dec_rs;
  assign rf_raddr1 = dec_rt;
  assign fwd_a     = (wb_we && wb_addr == dec_rs) ? wb_data : rf_rdata0;
  assign fwd_b     = (wb_we && wb_addr == dec_rt) ? wb_data : rf_rdata1;

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    ex_valid_d   = ex_valid_q;
    ex_op_d      = ex_op_q;
    ex_a_d       = ex_a_q;
    ex_b_d       = ex_b_q;
    ex_rd_d      = ex_rd_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_snoop_b_d = ex_snoop_b_q;
    err_d        = err_q;
    cnt_d        = cnt_q;

    if (ex_valid_q && ex_ready) cnt_d = cnt_q + 1'b1;

    // A held instruction must not go stale while it waits for the ALU.
    if (stall && wb_we) begin
      if (wb_addr == ex_rs_q) ex_a_d = wb_data;
      if (ex_snoop_b_q && wb_addr == ex_rt_q) ex_b_d = wb_data;
    end

    if (can_load) ex_valid_d = 1'b0;

    if (consume) begin
      if (dec_is_illegal) err_d = 1'b1;
      if (!dec_is_nop && !dec_is_illegal) begin
        ex_valid_d   = 1'b1;
        ex_op_d      = dec_op;
        ex_a_d       = fwd_a;
        ex_b_d       = dec_is_imm ? DW'(dec_imm8) : fwd_b;
        ex_rd_d      = dec_rd;
        ex_rs_d      = dec_rs;
        ex_rt_d      = dec_rt;
        ex_snoop_b_d = !dec_is_imm;
      end
    end

    if (skid_valid_q) begin
      if (can_load) skid_valid_d = 1'b0;
    end else if (accept && !can_load) begin
      skid_valid_d = 1'b1;
      skid_instr_d = in_instr;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      in_ready_q   <= 1'b0;
      ex_valid_q   <= 1'b0;
      ex_op_q      <= '0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_rd_q      <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_snoop_b_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      in_ready_q   <= in_ready_d;
      ex_valid_q   <= ex_valid_d;
      ex_op_q      <= ex_op_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      ex_rd_q      <= ex_rd_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_snoop_b_q <= ex_snoop_b_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign ex_valid    = ex_valid_q;
  assign ex_op       = ex_op_q;
  assign ex_a        = ex_a_q;
  assign ex_b        = ex_b_q;
  assign ex_rd       = ex_rd_q;
  assign err_illegal = err_q;
  assign issue_cnt   = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized traffic
// scored against an in-order queue and a register-file model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic [1:0]  rf_raddr0, rf_raddr1;
  logic [7:0]  rf_rdata0, rf_rdata1;
  logic        wb_we = 1'b0;
  logic [1:0]  wb_addr = '0;
  logic [7:0]  wb_data = '0;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [3:0]  ex_op;
  logic [7:0]  ex_a, ex_b;
  logic [1:0]  ex_rd;
  logic        err_illegal;
  logic [15:0] issue_cnt;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .rf_raddr0   (rf_raddr0),
    .rf_raddr1   (rf_raddr1),
    .rf_rdata0   (rf_rdata0),
    .rf_rdata1   (rf_rdata1),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_op       (ex_op),
    .ex_a        (ex_a),
    .ex_b        (ex_b),
    .ex_rd       (ex_rd),
    .err_illegal (err_illegal),
    .issue_cnt   (issue_cnt)
  );

  logic [7:0] regs [0:3];
  assign rf_rdata0 = regs[rf_raddr0];
  assign rf_rdata1 = regs[rf_raddr1];

  typedef struct {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [1:0] rt;
    logic       isImm;
    logic [7:0] imm;
  } expInstr_t;

  expInstr_t expQ[$];
  int checkCount = 0;
  int errorCount = 0;
  int issuedCount = 0;
  int acceptCount = 0;
  bit sawIllegal = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] mkR(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt);
    return {op, rd, rs, rt, 6'b0};
  endfunction

  function automatic logic [15:0] mkI(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // One clock cycle: drive, score the presented instruction, then advance the models.
  task automatic applyStimulus(input bit iv, input logic [15:0] instr, input bit er,
                               input bit we, input logic [1:0] wa, input logic [7:0] wd);
    bit acc, cons;
    expInstr_t e;
    @(negedge clk);
    in_valid = iv;
    in_instr = instr;
    ex_ready = er;
    wb_we    = we;
    wb_addr  = wa;
    wb_data  = wd;
    #2;
    acc  = in_valid && in_ready;
    cons = ex_valid && ex_ready;
    if (ex_valid) begin
      checkOutput("ex_has_entry", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        e = expQ[0];
        checkOutput("ex_op", 32'(ex_op), 32'(e.op));
        checkOutput("ex_rd", 32'(ex_rd), 32'(e.rd));
        checkOutput("ex_a", 32'(ex_a), 32'(regs[e.rs]));
        checkOutput("ex_b", 32'(ex_b), e.isImm ? 32'(e.imm) : 32'(regs[e.rt]));
      end
    end
    checkOutput("issue_cnt", 32'(issue_cnt), 32'(issuedCount % 65536));
    @(posedge clk);
    #1;
    if (cons && expQ.size() != 0) begin
      void'(expQ.pop_front());
      issuedCount++;
    end
    if (acc) begin
      acceptCount++;
      e.op    = instr[15:12];
      e.rd    = instr[11:10];
      e.rs    = instr[9:8];
      e.rt    = instr[7:6];
      e.imm   = instr[7:0];
      e.isImm = (e.op < 4'd8);
      if (e.op == 4'd14) sawIllegal = 1'b1;
      else if (e.op != 4'd0) expQ.push_back(e);
    end
    if (we) regs[wa] = wd;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout reached at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int baseCnt, baseAcc;
    logic [15:0] i1, i2, i3;
    bit rIv, rEr, rWe;

    regs[0] = 8'h10; regs[1] = 8'h11; regs[2] = 8'h05; regs[3] = 8'h03;

    repeat (2) @(negedge clk);
    checkOutput("rst_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_err", 32'(err_illegal), 32'd0);
    checkOutput("rst_cnt", 32'(issue_cnt), 32'd0);
    rst_n = 1'b1;
    applyStimulus(0, 16'h0, 1, 0, 2'd0, 8'h0);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    // NOP is consumed without issuing or flagging
    baseAcc = acceptCount;
    applyStimulus(1, 16'h0000, 1, 0, 2'd0, 8'h0);
    checkOutput("nop_accepted", 32'(acceptCount - baseAcc), 32'd1);
    checkOutput("nop_no_issue", 32'(ex_valid), 32'd0);
    checkOutput("nop_no_err", 32'(err_illegal), 32'd0);

    applyStimulus(1, mkR(4'b1000, 2'd1, 2'd2, 2'd3), 1, 0, 2'd0, 8'h0);
    checkOutput("add_valid", 32'(ex_valid), 32'd1);
    checkOutput("add_op", 32'(ex_op), 32'h8);
    checkOutput("add_a", 32'(ex_a), 32'h05);
    checkOutput("add_b", 32'(ex_b), 32'h03);
    checkOutput("add_rd", 32'(ex_rd), 32'd1);

    // imm8 0xF0 puts 2'b11 in the rt field; the wb to r3 must not leak into B
    applyStimulus(1, mkI(4'b0001, 2'd2, 2'd1, 8'hF0), 1, 1, 2'd3, 8'h55);
    checkOutput("addi_b", 32'(ex_b), 32'hF0);
    checkOutput("addi_a", 32'(ex_a), 32'h11);

    applyStimulus(1, mkR(4'b1000, 2'd0, 2'd2, 2'd1), 1, 1, 2'd2, 8'h7F);
    checkOutput("fwd_a", 32'(ex_a), 32'h7F);
    checkOutput("fwd_b", 32'(ex_b), 32'h11);
    applyStimulus(0, 16'h0, 1, 0, 2'd0, 8'h0);

    // Backpressure: three back-to-back inputs against a stalled output
    regs[0] = 8'h10; regs[1] = 8'h21; regs[2] = 8'h7F; regs[3] = 8'h55;
    i1 = mkR(4'b1000, 2'd0, 2'd1, 2'd2);
    i2 = mkI(4'b0010, 2'd1, 2'd3, 8'h0C);
    i3 = mkR(4'b1011, 2'd2, 2'd0, 2'd3);
    baseCnt = issuedCount;
    baseAcc = acceptCount;
    applyStimulus(1, i1, 0, 0, 2'd0, 8'h0);
    checkOutput("bp_first_valid", 32'(ex_valid), 32'd1);
    applyStimulus(1, i2, 0, 1, 2'd1, 8'h99);
    checkOutput("bp_snoop_a", 32'(ex_a), 32'h99);
    checkOutput("bp_skid_full", 32'(in_ready), 32'd0);
    applyStimulus(1, i3, 0, 0, 2'd0, 8'h0);
    checkOutput("bp_accepted2", 32'(acceptCount - baseAcc), 32'd2);
    checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    checkOutput("bp_hold_op", 32'(ex_op), 32'h8);
    applyStimulus(1, i3, 1, 0, 2'd0, 8'h0);
    checkOutput("bp_skid_out_op", 32'(ex_op), 32'h2);
    checkOutput("bp_in_ready_back", 32'(in_ready), 32'd1);
    checkOutput("bp_third_waits", 32'(acceptCount - baseAcc), 32'd2);
    applyStimulus(1, i3, 1, 0, 2'd0, 8'h0);
    checkOutput("bp_third_op", 32'(ex_op), 32'hB);
    applyStimulus(0, 16'h0, 1, 0, 2'd0, 8'h0);
    checkOutput("bp_cnt", 32'(issue_cnt), 32'(baseCnt + 3));
    checkOutput("bp_idle", 32'(ex_valid), 32'd0);

    applyStimulus(1, 16'hE123, 1, 0, 2'd0, 8'h0);
    checkOutput("ill_no_issue", 32'(ex_valid), 32'd0);
    checkOutput("ill_err", 32'(err_illegal), 32'd1);
    applyStimulus(1, 16'h0000, 1, 0, 2'd0, 8'h0);
    applyStimulus(0, 16'h0, 1, 0, 2'd0, 8'h0);
    checkOutput("ill_sticky", 32'(err_illegal), 32'd1);

    for (int n = 0; n < 400; n++) begin
      rIv = ($urandom_range(0, 3) != 0);
      rEr = ($urandom_range(0, 3) != 0);
      rWe = ($urandom_range(0, 1) != 0);
      applyStimulus(rIv, 16'($urandom), rEr, rWe, 2'($urandom), 8'($urandom));
    end
    for (int n = 0; n < 20 && (expQ.size() != 0 || ex_valid); n++)
      applyStimulus(0, 16'h0, 1, 0, 2'd0, 8'h0);
    applyStimulus(0, 16'h0, 1, 0, 2'd0, 8'h0);
    checkOutput("drain_queue", 32'(expQ.size()), 32'd0);
    checkOutput("drain_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("drain_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rand_err", 32'(err_illegal), 32'(sawIllegal));

    // Asynchronous reset in the middle of a stall
    applyStimulus(1, mkR(4'b1001, 2'd3, 2'd0, 2'd1), 0, 0, 2'd0, 8'h0);
    applyStimulus(0, 16'h0, 0, 0, 2'd0, 8'h0);
    checkOutput("pre_rst_stalled", 32'(ex_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("mid_rst_cnt", 32'(issue_cnt), 32'd0);
    checkOutput("mid_rst_err", 32'(err_illegal), 32'd0);
    expQ.delete();
    issuedCount = 0;
    sawIllegal = 1'b0;
    in_valid = 1'b0;
    ex_ready = 1'b0;
    wb_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 16'h0, 1, 0, 2'd0, 8'h0);
    checkOutput("after_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("after_rst_ex_valid", 32'(ex_valid), 32'd0);
    applyStimulus(1, mkI(4'b0111, 2'd1, 2'd2, 8'h3C), 1, 0, 2'd0, 8'h0);
    applyStimulus(0, 16'h0, 1, 0, 2'd0, 8'h0);
    checkOutput("after_rst_cnt", 32'(issue_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
